// File: rtl/uart_tx_if.sv
// Host-side bundle for the UART transmitter: baud tick, request/data in, line and status out.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_rate;
    logic                 tx_start;
    logic [DATA_BITS-1:0] d_in;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output baud_rate, tx_start, d_in,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  baud_rate, tx_start, d_in,
        output tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits,
// bit timing from a shared OVERSAMPLE-per-bit baud tick.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus
);

    localparam int unsigned TICK_W    = $clog2(STOP_BITS * OVERSAMPLE);
    localparam int unsigned BIT_W     = $clog2(DATA_BITS);
    localparam int unsigned BIT_LAST  = OVERSAMPLE - 1;
    localparam int unsigned STOP_LAST = STOP_BITS * OVERSAMPLE - 1;
    localparam int unsigned DATA_LAST = DATA_BITS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [TICK_W-1:0]    tick_q, tick_nxt;
    logic [BIT_W-1:0]     bit_q, bit_nxt;
    logic                 tx_q, tx_nxt;
    logic                 busy_q, busy_nxt;
    logic                 done_q, done_nxt;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            tick_q  <= tick_nxt;
            bit_q   <= bit_nxt;
            tx_q    <= tx_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next state; tx/busy follow the current state so the line lags the FSM by one clk
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        tick_nxt  = tick_q;
        bit_nxt   = bit_q;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (bus.tx_start) begin
                    shift_nxt = bus.d_in;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = START;
                end
            end

            START: begin
                tx_nxt = 1'b0;
                if (bus.baud_rate) begin
                    if (tick_q == TICK_W'(BIT_LAST)) begin
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = DATA;
                    end else begin
                        tick_nxt = tick_q + TICK_W'(1);
                    end
                end
            end

            DATA: begin
                tx_nxt = shift_q[0];
                if (bus.baud_rate) begin
                    if (tick_q == TICK_W'(BIT_LAST)) begin
                        tick_nxt  = '0;
                        shift_nxt = shift_q >> 1;
                        if (bit_q == BIT_W'(DATA_LAST)) begin
                            bit_nxt   = '0;
                            state_nxt = STOP;
                        end else begin
                            bit_nxt = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_nxt = tick_q + TICK_W'(1);
                    end
                end
            end

            STOP: begin
                if (bus.baud_rate) begin
                    if (tick_q == TICK_W'(STOP_LAST)) begin
                        tick_nxt  = '0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tick_nxt = tick_q + TICK_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule
